serial_bus_arbiter: RTL and testbench

Shares the single serial slave bus (control / wD / valid / last out, rD / ready back) between MASTERS requesters. Grants are round-robin and held until the owning master drops its request, or until an optional watchdog expires. A one-cycle idle turnaround separates successive owners. The block also snoops the granted master's control frame (start 111 | slave ID | R/W | B | start address) and publishes the decoded header for the top module.

---
 rtl/serial_bus_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// -----------------------------------------------------------------------------
// serial_bus_arbiter
//
// Shares one serial slave bus between MASTERS requesters. Grants are handed
// out round-robin and held until the owner drops its request, or until the
// optional watchdog revokes them. Every change of owner passes through one
// idle turnaround cycle. While a master owns the bus, its control line is
// snooped and the frame header (start 111 | slave ID | R/W | B | address) is
// decoded and published on the frame_* outputs.
//
// Ports
//   clk, rstN                 clock, asynchronous active-low reset
//   m_req                     per-master request (level)
//   m_grant                   one-hot registered grant
//   m_control/wD/valid/last   per-master serial bus drive
//   m_rD, m_ready             per-master copies of the slave return signals
//   bus_control/wD/valid/last shared bus towards the slaves
//   bus_rD, bus_ready         shared bus from the slaves
//   frame_valid               header of the current grant fully captured
//   frame_slave/write/burst/addr  decoded header fields
//   frame_err                 captured slave ID is out of range
//   timeout_err               one-cycle pulse when the watchdog revokes
// -----------------------------------------------------------------------------
module serial_bus_arbiter #(
    parameter int MASTERS    = 2,
    parameter int SLAVES     = 3,
    parameter int ADDR_WIDTH = 11,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [MASTERS-1:0]    m_req,
    output logic [MASTERS-1:0]    m_grant,
    input  logic [MASTERS-1:0]    m_control,
    input  logic [MASTERS-1:0]    m_wD,
    input  logic [MASTERS-1:0]    m_valid,
    input  logic [MASTERS-1:0]    m_last,
    output logic [MASTERS-1:0]    m_rD,
    output logic [MASTERS-1:0]    m_ready,
    output logic                  bus_control,
    output logic                  bus_wD,
    output logic                  bus_valid,
    output logic                  bus_last,
    input  logic                  bus_rD,
    input  logic                  bus_ready,
    output logic                  frame_valid,
    output logic [1:0]            frame_slave,
    output logic                  frame_write,
    output logic                  frame_burst,
    output logic [ADDR_WIDTH-1:0] frame_addr,
    output logic                  frame_err,
    output logic                  timeout_err
);

    localparam int          OW      = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int          HW      = 4 + ADDR_WIDTH;     // header bits after start
    localparam int          BW      = $clog2(HW);
    localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} arb_state_e;
    typedef enum logic [1:0] {SN_HUNT, SN_HDR, SN_DONE} snoop_state_e;

    arb_state_e             state_q;
    snoop_state_e           snoop_q;
    logic [MASTERS-1:0]     req_q;
    logic [MASTERS-1:0]     blocked_q;
    logic [MASTERS-1:0]     grant_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          last_owner_q;
    logic [CW-1:0]          wd_cnt_q;
    logic [1:0]             ones_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [HW-2:0]          hdr_q;
    logic                   frame_valid_q;
    logic [1:0]             frame_slave_q;
    logic                   frame_write_q;
    logic                   frame_burst_q;
    logic [ADDR_WIDTH-1:0]  frame_addr_q;
    logic                   frame_err_q;
    logic                   timeout_err_q;

    logic [MASTERS-1:0]     req_eff_d;
    logic                   win_found_d;
    logic [OW-1:0]          win_idx_d;
    logic                   owner_req_d;
    logic                   wd_expire_d;
    logic [HW-1:0]          hdr_full_d;
    logic                   id_bad_d;

    // Requests pass through one register stage; the arbiter acts on the
    // sampled copy, so a request seen at edge N is granted after edge N+1 and
    // a release seen at edge N removes the grant after edge N+1.
    // Masters revoked by the watchdog stay masked until seen low once.
    assign req_eff_d   = req_q & ~blocked_q;
    assign owner_req_d = req_q[owner_q];
    assign wd_expire_d = (TIMEOUT != 0) && (wd_cnt_q == CW'(TO_LAST));

    // Complete header including the bit being sampled on this edge.
    assign hdr_full_d  = {hdr_q, bus_control};
    assign id_bad_d    = (int'(hdr_full_d[HW-1 -: 2]) >= SLAVES);

    // Round-robin pick: scan downwards so the nearest index after the last
    // owner is the one left standing.
    always_comb begin
        int idx;
        win_found_d = 1'b0;
        win_idx_d   = '0;
        idx         = 0;
        for (int k = MASTERS; k >= 1; k--) begin
            idx = (int'(last_owner_q) + k) % MASTERS;
            if (req_eff_d[idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = OW'(idx);
            end
        end
    end

    // Grant is one-hot and only non-zero in OWN, so an AND/OR reduction is
    // the bus multiplexer and the idle value falls out as zero.
    assign bus_control = |(grant_q & m_control);
    assign bus_wD      = |(grant_q & m_wD);
    assign bus_valid   = |(grant_q & m_valid);
    assign bus_last    = |(grant_q & m_last);

    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_return
        assign m_rD[gi]    = grant_q[gi] & bus_rD;
        assign m_ready[gi] = grant_q[gi] & bus_ready;
    end

    assign m_grant     = grant_q;
    assign frame_valid = frame_valid_q;
    assign frame_slave = frame_slave_q;
    assign frame_write = frame_write_q;
    assign frame_burst = frame_burst_q;
    assign frame_addr  = frame_addr_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_IDLE;
            snoop_q       <= SN_HUNT;
            req_q         <= '0;
            blocked_q     <= '0;
            grant_q       <= '0;
            owner_q       <= '0;
            last_owner_q  <= OW'(MASTERS - 1);
            wd_cnt_q      <= '0;
            ones_q        <= '0;
            bit_cnt_q     <= '0;
            hdr_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_slave_q <= '0;
            frame_write_q <= 1'b0;
            frame_burst_q <= 1'b0;
            frame_addr_q  <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            req_q         <= m_req;
            timeout_err_q <= 1'b0;
            // A low sample of the request lifts any watchdog block.
            blocked_q     <= blocked_q & req_q;

            case (state_q)
                ST_IDLE: begin
                    if (win_found_d) begin
                        state_q  <= ST_OWN;
                        owner_q  <= win_idx_d;
                        grant_q  <= {{(MASTERS-1){1'b0}}, 1'b1} << win_idx_d;
                        wd_cnt_q <= '0;
                    end
                end

                ST_OWN: begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    if (!owner_req_d || wd_expire_d) begin
                        state_q       <= ST_TURN;
                        grant_q       <= '0;
                        last_owner_q  <= owner_q;
                        snoop_q       <= SN_HUNT;
                        ones_q        <= '0;
                        bit_cnt_q     <= '0;
                        frame_valid_q <= 1'b0;
                        frame_err_q   <= 1'b0;
                        // Still requesting means the watchdog forced the release.
                        if (owner_req_d) begin
                            timeout_err_q      <= 1'b1;
                            blocked_q[owner_q] <= 1'b1;
                        end
                    end else begin
                        case (snoop_q)
                            SN_HUNT: begin
                                if (bus_control) begin
                                    if (ones_q == 2'd2) begin
                                        snoop_q   <= SN_HDR;
                                        bit_cnt_q <= '0;
                                    end else begin
                                        ones_q <= ones_q + 2'd1;
                                    end
                                end else begin
                                    ones_q <= '0;
                                end
                            end
                            SN_HDR: begin
                                hdr_q     <= hdr_full_d[HW-2:0];
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                if (bit_cnt_q == BW'(HW - 1)) begin
                                    snoop_q       <= SN_DONE;
                                    frame_valid_q <= 1'b1;
                                    frame_slave_q <= hdr_full_d[HW-1 -: 2];
                                    frame_write_q <= hdr_full_d[HW-3];
                                    frame_burst_q <= hdr_full_d[HW-4];
                                    frame_addr_q  <= hdr_full_d[ADDR_WIDTH-1:0];
                                    frame_err_q   <= id_bad_d;
                                end
                            end
                            default: begin
                                // DONE: control is ignored until the grant ends.
                            end
                        endcase
                    end
                end

                ST_TURN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
module tb_serial_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  m_req, m_control, m_wD, m_valid, m_last;
    logic        bus_rD, bus_ready;
    logic [1:0]  m_grant, m_rD, m_ready;
    logic        bus_control, bus_wD, bus_valid, bus_last;
    logic        frame_valid, frame_write, frame_burst, frame_err, timeout_err;
    logic [1:0]  frame_slave;
    logic [10:0] frame_addr;

    // Second instance with a short watchdog.
    logic [1:0]  w_req;
    logic [1:0]  w_grant, w_rD, w_ready;
    logic        w_bus_control, w_bus_wD, w_bus_valid, w_bus_last;
    logic        w_frame_valid, w_frame_write, w_frame_burst, w_frame_err, w_timeout_err;
    logic [1:0]  w_frame_slave;
    logic [10:0] w_frame_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_bus_arbiter #(.MASTERS(2), .SLAVES(3), .ADDR_WIDTH(11), .TIMEOUT(4096)) dut (
        .clk(clk), .rstN(rstN), .m_req(m_req), .m_grant(m_grant),
        .m_control(m_control), .m_wD(m_wD), .m_valid(m_valid), .m_last(m_last),
        .m_rD(m_rD), .m_ready(m_ready),
        .bus_control(bus_control), .bus_wD(bus_wD), .bus_valid(bus_valid), .bus_last(bus_last),
        .bus_rD(bus_rD), .bus_ready(bus_ready),
        .frame_valid(frame_valid), .frame_slave(frame_slave), .frame_write(frame_write),
        .frame_burst(frame_burst), .frame_addr(frame_addr), .frame_err(frame_err),
        .timeout_err(timeout_err)
    );

    serial_bus_arbiter #(.MASTERS(2), .SLAVES(3), .ADDR_WIDTH(11), .TIMEOUT(16)) dut_wd (
        .clk(clk), .rstN(rstN), .m_req(w_req), .m_grant(w_grant),
        .m_control(2'b00), .m_wD(2'b00), .m_valid(2'b00), .m_last(2'b00),
        .m_rD(w_rD), .m_ready(w_ready),
        .bus_control(w_bus_control), .bus_wD(w_bus_wD), .bus_valid(w_bus_valid), .bus_last(w_bus_last),
        .bus_rD(1'b0), .bus_ready(1'b0),
        .frame_valid(w_frame_valid), .frame_slave(w_frame_slave), .frame_write(w_frame_write),
        .frame_burst(w_frame_burst), .frame_addr(w_frame_addr), .frame_err(w_frame_err),
        .timeout_err(w_timeout_err)
    );

    task automatic clear_inputs();
        m_control = '0; m_wD = '0; m_valid = '0; m_last = '0;
        bus_rD = 1'b0; bus_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        m_req = '0; w_req = '0;
        m_control = 2'b11; m_wD = 2'b11; m_valid = 2'b11; m_last = 2'b11;
        bus_rD = 1'b1; bus_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m_grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", m_grant); end
        total++; if ({bus_control, bus_wD, bus_valid, bus_last} !== 4'b0000) begin bad++;
            $display("FAIL reset_bus: got %b want 0000", {bus_control, bus_wD, bus_valid, bus_last}); end
        total++; if ({m_rD, m_ready} !== 4'b0000) begin bad++; $display("FAIL reset_return: got %b want 0000", {m_rD, m_ready}); end
        total++; if ({frame_valid, frame_err, timeout_err} !== 3'b000) begin bad++;
            $display("FAIL reset_flags: got %b want 000", {frame_valid, frame_err, timeout_err}); end
        total++; if ({frame_slave, frame_write, frame_burst, frame_addr} !== 15'd0) begin bad++;
            $display("FAIL reset_fields: got %h want 0", {frame_slave, frame_write, frame_burst, frame_addr}); end
        total++; if ({w_grant, w_timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_wd: got %b want 000", {w_grant, w_timeout_err}); end
        clear_inputs();
        rstN = 1'b1;
        @(posedge clk); #1;
        total++; if (m_grant !== 2'b00) begin bad++; $display("FAIL reset_nogrant: got %b want 00", m_grant); end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_frame();
        logic [17:0] fr;
        fr = {3'b111, 2'b01, 1'b1, 1'b1, 11'd0};
        m_req = 2'b01;
        @(posedge clk); #1;
        total++; if (m_grant !== 2'b00) begin bad++; $display("FAIL grant_early: got %b want 00", m_grant); end
        @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL grant_single: got %b want 01", m_grant); end
        for (int i = 17; i >= 0; i--) begin
            m_control = {1'($urandom), fr[i]};
            m_wD = 2'($urandom); m_valid = 2'($urandom); m_last = 2'($urandom);
            #1;
            total++; if ({bus_control, bus_wD, bus_valid, bus_last} !== {m_control[0], m_wD[0], m_valid[0], m_last[0]}) begin bad++;
                $display("FAIL bus_mirror: got %b want %b", {bus_control, bus_wD, bus_valid, bus_last},
                         {m_control[0], m_wD[0], m_valid[0], m_last[0]}); end
            if (i == 0) begin
                total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL frame_early: got %b want 0", frame_valid); end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        total++; if ({frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr} !== {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 11'd0}) begin bad++;
            $display("FAIL frame_single: got %h want %h", {frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr},
                     {1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 11'd0}); end
        m_req = 2'b00;
        @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL release_hold: got %b want 01", m_grant); end
        @(posedge clk); #1;
        total++; if ({m_grant, frame_valid} !== 3'b000) begin bad++; $display("FAIL release_drop: got %b want 000", {m_grant, frame_valid}); end
        @(posedge clk); #1;
        $display("single: master 0 frame slave=1 write=1 burst=1 addr=0");
    endtask

    task automatic test_contention();
        logic [1:0] exp_a [4];
        logic [1:0] exp_b [4];
        exp_a = '{2'b01, 2'b00, 2'b00, 2'b10};
        exp_b = '{2'b10, 2'b00, 2'b00, 2'b01};
        rstN = 1'b0; m_req = 2'b00;
        @(posedge clk); #1;
        rstN = 1'b1;
        m_req = 2'b11;
        m_control = 2'b11; m_wD = 2'b11;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL cont_first: got %b want 01", m_grant); end
        m_req = 2'b10;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            total++; if (m_grant !== exp_a[e]) begin bad++; $display("FAIL cont_handover[%0d]: got %b want %b", e, m_grant, exp_a[e]); end
            if (exp_a[e] == 2'b00) begin
                total++; if ({bus_control, bus_wD} !== 2'b00) begin bad++; $display("FAIL cont_idle_bus[%0d]: got %b want 00", e, {bus_control, bus_wD}); end
            end
        end
        m_req = 2'b01;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            if (e == 0) m_req = 2'b11;
            total++; if (m_grant !== exp_b[e]) begin bad++; $display("FAIL cont_rr[%0d]: got %b want %b", e, m_grant, exp_b[e]); end
        end
        clear_inputs();
        $display("contention: 0 -> 1 -> 0 handover checked");
    endtask

    task automatic test_read_path();
        m_req = 2'b10;
        repeat (4) @(posedge clk);
        #1;
        total++; if (m_grant !== 2'b10) begin bad++; $display("FAIL read_grant: got %b want 10", m_grant); end
        for (int c = 0; c < 8; c++) begin
            bus_rD = c[0]; bus_ready = 1'($urandom);
            #1;
            total++; if ({m_rD, m_ready} !== {bus_rD, 1'b0, bus_ready, 1'b0}) begin bad++;
                $display("FAIL read_path[%0d]: got %b want %b", c, {m_rD, m_ready}, {bus_rD, 1'b0, bus_ready, 1'b0}); end
            @(posedge clk); #1;
        end
        m_req = 2'b00; clear_inputs();
        repeat (4) @(posedge clk);
        #1;
        $display("read: master 1 return path checked");
    endtask

    task automatic test_bad_id();
        logic [17:0] fr;
        fr = {3'b111, 2'b11, 1'b0, 1'b0, 11'd3};
        m_req = 2'b01;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL badid_grant: got %b want 01", m_grant); end
        for (int i = 17; i >= 0; i--) begin
            m_control = {1'b0, fr[i]};
            @(posedge clk); #1;
        end
        m_control = '0;
        total++; if ({frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr} !== {1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 11'd3}) begin bad++;
            $display("FAIL badid_frame: got %h want %h", {frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr},
                     {1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 11'd3}); end
        m_req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        $display("badid: slave 3 flagged");
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 6; it++) begin
            int m;
            logic [1:0] id;
            logic w, b;
            logic [10:0] addr;
            logic [17:0] fr;
            logic [3:0] noise;
            m = int'($urandom_range(0, 1));
            id = 2'($urandom_range(0, 3));
            w = 1'($urandom); b = 1'($urandom);
            addr = 11'($urandom_range(0, 2047));
            fr = {3'b111, id, w, b, addr};
            noise = 4'b0110;
            m_req = 2'b01 << m;
            @(posedge clk); #1; @(posedge clk); #1;
            total++; if (m_grant !== (2'b01 << m)) begin bad++; $display("FAIL rfr_grant[%0d]: got %b want %b", it, m_grant, 2'b01 << m); end
            for (int i = 3; i >= 0; i--) begin
                m_control[m] = noise[i];
                @(posedge clk); #1;
            end
            for (int i = 17; i >= 0; i--) begin
                m_control[m] = fr[i];
                if (i == 0) begin
                    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rfr_early[%0d]: got %b want 0", it, frame_valid); end
                end
                @(posedge clk); #1;
            end
            m_control = '0;
            total++; if ({frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr} !== {1'b1, (id == 2'd3), id, w, b, addr}) begin bad++;
                $display("FAIL rfr_frame[%0d]: got %h want %h", it, {frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr},
                         {1'b1, (id == 2'd3), id, w, b, addr}); end
            m_req = 2'b00;
            @(posedge clk); #1; @(posedge clk); #1;
            total++; if ({m_grant, frame_valid, frame_err} !== 4'b0000) begin bad++;
                $display("FAIL rfr_clear[%0d]: got %b want 0000", it, {m_grant, frame_valid, frame_err}); end
            @(posedge clk); #1;
            $display("frame: master %0d id=%0d w=%0d b=%0d addr=%0d", m, id, w, b, addr);
        end
    endtask

    task automatic test_random_arbitration();
        int own, hold, last, grants;
        logic [1:0] rq, req, exp_grant, exp_ret;
        logic [3:0] exp_bus;
        rstN = 1'b0; m_req = '0; clear_inputs();
        @(posedge clk); #1;
        rstN = 1'b1;
        own = -1; hold = 0; last = 1; rq = 2'b00; req = 2'b00; grants = 0;
        for (int c = 0; c < 400; c++) begin
            req = req ^ {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            m_req = req;
            m_control = 2'($urandom); m_wD = 2'($urandom); m_valid = 2'($urandom); m_last = 2'($urandom);
            bus_rD = 1'($urandom); bus_ready = 1'($urandom);
            #1;
            exp_grant = (own >= 0) ? (2'b01 << own) : 2'b00;
            exp_bus = (own >= 0) ? {m_control[own], m_wD[own], m_valid[own], m_last[own]} : 4'b0000;
            exp_ret = (own >= 0) ? ({1'b0, bus_rD} << own) : 2'b00;
            total++; if (m_grant !== exp_grant) begin bad++; $display("FAIL rarb_grant[%0d]: got %b want %b", c, m_grant, exp_grant); end
            total++; if ({bus_control, bus_wD, bus_valid, bus_last, m_rD} !== {exp_bus, exp_ret}) begin bad++;
                $display("FAIL rarb_mux[%0d]: got %b want %b", c, {bus_control, bus_wD, bus_valid, bus_last, m_rD}, {exp_bus, exp_ret}); end
            @(posedge clk);
            // Reference: release after the sampled request falls, one blank
            // edge for the turnaround, then nearest requester after the last owner.
            if (own >= 0) begin
                if (!rq[own]) begin last = own; own = -1; hold = 1; end
            end else if (hold > 0) begin
                hold--;
            end else begin
                for (int k = 1; k <= 2; k++) begin
                    int i;
                    i = (last + k) % 2;
                    if (rq[i]) begin
                        own = i; grants++;
                        break;
                    end
                end
            end
            rq = req;
            #1;
        end
        m_req = '0; clear_inputs();
        repeat (4) @(posedge clk);
        #1;
        $display("random arbitration: 400 cycles, %0d grants modelled", grants);
    endtask

    task automatic test_watchdog();
        w_req = 2'b01;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (w_grant !== 2'b01) begin bad++; $display("FAIL wd_grant: got %b want 01", w_grant); end
        for (int k = 1; k <= 15; k++) begin
            if (k == 8) w_req = 2'b11;
            @(posedge clk); #1;
            total++; if ({w_grant, w_timeout_err} !== 3'b010) begin bad++; $display("FAIL wd_hold[%0d]: got %b want 010", k, {w_grant, w_timeout_err}); end
        end
        @(posedge clk); #1;
        total++; if ({w_grant, w_timeout_err} !== 3'b001) begin bad++; $display("FAIL wd_revoke: got %b want 001", {w_grant, w_timeout_err}); end
        @(posedge clk); #1;
        total++; if ({w_grant, w_timeout_err} !== 3'b000) begin bad++; $display("FAIL wd_pulse_end: got %b want 000", {w_grant, w_timeout_err}); end
        @(posedge clk); #1;
        total++; if (w_grant !== 2'b10) begin bad++; $display("FAIL wd_next: got %b want 10", w_grant); end
        w_req = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            total++; if ({w_grant[0], w_timeout_err} !== 2'b00) begin bad++; $display("FAIL wd_blocked[%0d]: got %b want 00", k, {w_grant[0], w_timeout_err}); end
        end
        w_req = 2'b00;
        @(posedge clk); #1;
        w_req = 2'b01;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (w_grant !== 2'b01) begin bad++; $display("FAIL wd_regrant: got %b want 01", w_grant); end
        w_req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        $display("watchdog: revoke after 16 cycles, block until request drops");
    endtask

    task automatic test_reset_mid_frame();
        logic [17:0] fr;
        fr = {3'b111, 2'b10, 1'b0, 1'b1, 11'h5A5};
        m_req = 2'b01;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL rst_grant: got %b want 01", m_grant); end
        for (int i = 17; i >= 8; i--) begin
            m_control = {1'b0, fr[i]};
            @(posedge clk); #1;
        end
        m_control = 2'b01; m_wD = 2'b01; m_valid = 2'b01; m_last = 2'b01; bus_ready = 1'b1;
        #1;
        total++; if ({bus_control, bus_wD, bus_valid, bus_last} !== 4'b1111) begin bad++;
            $display("FAIL rst_pre_bus: got %b want 1111", {bus_control, bus_wD, bus_valid, bus_last}); end
        rstN = 1'b0;
        #1;
        total++; if ({m_grant, bus_control, bus_wD, bus_valid, bus_last, m_ready} !== 8'd0) begin bad++;
            $display("FAIL rst_async: got %b want 00000000", {m_grant, bus_control, bus_wD, bus_valid, bus_last, m_ready}); end
        total++; if ({frame_valid, frame_err, timeout_err, frame_addr} !== 14'd0) begin bad++;
            $display("FAIL rst_frame: got %h want 0", {frame_valid, frame_err, timeout_err, frame_addr}); end
        @(posedge clk); #1;
        rstN = 1'b1;
        clear_inputs();
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (m_grant !== 2'b01) begin bad++; $display("FAIL rst_regrant: got %b want 01", m_grant); end
        for (int i = 17; i >= 0; i--) begin
            m_control = {1'b0, fr[i]};
            @(posedge clk); #1;
        end
        m_control = '0;
        total++; if ({frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr} !== {1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 11'h5A5}) begin bad++;
            $display("FAIL rst_newframe: got %h want %h", {frame_valid, frame_err, frame_slave, frame_write, frame_burst, frame_addr},
                     {1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 11'h5A5}); end
        m_req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        $display("reset mid-frame: recovery frame slave=2 addr=0x5a5");
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_read_path();
        test_bad_id();
        test_random_frames();
        test_watchdog();
        test_random_arbitration();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
